register_map_table: RTL

//  Parametrised logical->physical register mapping table. Successor to the 4-entry SWAP mapper.

---
 rtl/register_map_table_if.sv | 26 ++
 rtl/register_map_table.sv | 74 +++++++
 2 files changed

// File: rtl/register_map_table_if.sv
// register_map_table_if: decoder-side op/lookup bundle for the register map table
interface register_map_table_if #(
  parameter int NUM_REGS   = 4,
  parameter int CKPT_DEPTH = 2
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [REG_W-1:0] op_reg_a;
  logic [REG_W-1:0] op_reg_b;
  logic [REG_W-1:0] map_a;
  logic [REG_W-1:0] map_b;
  logic [CNT_W-1:0] ckpt_count;
  logic             ckpt_full;
  logic             ckpt_empty;
  logic             op_error;
  modport master (
    output op_valid, op_code, op_reg_a, op_reg_b,
    input  map_a, map_b, ckpt_count, ckpt_full, ckpt_empty, op_error
  );
  modport slave (
    input  op_valid, op_code, op_reg_a, op_reg_b,
    output map_a, map_b, ckpt_count, ckpt_full, ckpt_empty, op_error
  );
endinterface

// File: rtl/register_map_table.sv
// register_map_table: logical->physical register map with swap/rotate/clear and a checkpoint stack
module register_map_table #(
  parameter int NUM_REGS   = 4,
  parameter int CKPT_DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  register_map_table_if.slave bus
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);
  typedef logic [REG_W-1:0] tbl_t [NUM_REGS];
  tbl_t             tbl_q, tbl_d, id_tbl;
  tbl_t             stk_q [CKPT_DEPTH];
  tbl_t             stk_d [CKPT_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             a_ok, b_ok, full, empty;
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) id_tbl[i] = REG_W'(i);
  end
  assign a_ok            = 32'(bus.op_reg_a) < NUM_REGS;
  assign b_ok            = 32'(bus.op_reg_b) < NUM_REGS;
  assign full            = cnt_q == CNT_W'(CKPT_DEPTH);
  assign empty           = cnt_q == '0;
  assign bus.map_a       = a_ok ? tbl_q[bus.op_reg_a] : '0;
  assign bus.map_b       = b_ok ? tbl_q[bus.op_reg_b] : '0;
  assign bus.ckpt_count  = cnt_q;
  assign bus.ckpt_full   = full;
  assign bus.ckpt_empty  = empty;
  assign bus.op_error    = err_q;
  // stack slots are selected by comparing against the count so no index wider than the array is ever used
  always_comb begin
    tbl_d = tbl_q;
    stk_d = stk_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (bus.op_valid)
      case (bus.op_code)
        3'd1: if (a_ok && b_ok) begin
                tbl_d[bus.op_reg_a] = tbl_q[bus.op_reg_b];
                tbl_d[bus.op_reg_b] = tbl_q[bus.op_reg_a];
              end else err_d = 1'b1;
        3'd2: for (int i = 0; i < NUM_REGS; i++) tbl_d[i] = tbl_q[(i + 1) % NUM_REGS];
        3'd3: if (full) err_d = 1'b1;
              else begin
                for (int i = 0; i < CKPT_DEPTH; i++) if (cnt_q == CNT_W'(i)) stk_d[i] = tbl_q;
                cnt_d = cnt_q + CNT_W'(1);
              end
        3'd4: if (empty) err_d = 1'b1;
              else begin
                for (int i = 0; i < CKPT_DEPTH; i++) if (cnt_q == CNT_W'(i + 1)) tbl_d = stk_q[i];
                cnt_d = cnt_q - CNT_W'(1);
              end
        3'd5: if (empty) err_d = 1'b1;
              else cnt_d = cnt_q - CNT_W'(1);
        3'd6: tbl_d = id_tbl;
        3'd7: err_d = 1'b1;
        default: ;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_q <= id_tbl;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) stk_q <= stk_d;
endmodule
